// File: rtl/axis_tdm_deinterleave.sv
// Splits a channel-interleaved (TDM) AXI-Stream into NUM_CH parallel per-channel streams.
// A gather buffer collects one group and a pending output register holds it until every channel has handshaken.
module axis_tdm_deinterleave #(
   parameter int NUM_CH    = 4,
   parameter int DATA_W    = 32,
   parameter int SAMPLE_W  = 24,
   parameter int OUT_W     = 64,
   parameter int FRAME_LEN = 4096,
   parameter int SIGN_EXT  = 1
) (
   input  logic                    s00_axis_aclk,
   input  logic                    s00_axis_aresetn,
   input  logic [DATA_W-1:0]       s00_axis_tdata,
   input  logic                    s00_axis_tvalid,
   input  logic                    s00_axis_tlast,
   output logic                    s00_axis_tready,
   output logic [NUM_CH*OUT_W-1:0] m_axis_tdata,
   output logic [NUM_CH-1:0]       m_axis_tvalid,
   input  logic [NUM_CH-1:0]       m_axis_tready,
   output logic [NUM_CH-1:0]       m_axis_tlast,
   output logic                    frame_done,
   output logic                    frame_err,
   output logic [15:0]             err_cnt
);
   localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam int GW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
   localparam logic [CW-1:0] LAST_CH  = CW'(NUM_CH - 1);
   localparam logic [GW-1:0] LAST_GRP = GW'(FRAME_LEN - 1);

   logic [CW-1:0]             ch_idx_q, ch_idx_d;
   logic [SAMPLE_W-1:0]       gather_q [NUM_CH];
   logic [SAMPLE_W-1:0]       gather_d [NUM_CH];
   logic                      gather_full_q, gather_full_d;
   logic                      held_tlast_q, held_tlast_d;
   logic [NUM_CH-1:0]         pending_q, pending_d;
   logic [NUM_CH*OUT_W-1:0]   out_data_q, out_data_d;
   logic                      out_last_q, out_last_d;
   logic [GW-1:0]             grp_cnt_q, grp_cnt_d;
   logic                      frame_done_q, frame_done_d;
   logic                      frame_err_q, frame_err_d;
   logic [15:0]               err_cnt_q, err_cnt_d;

   logic [SAMPLE_W-1:0] sample_in;
   logic                accept, out_free, last_word, load, load_tlast, at_last_grp, ends_frame;

   function automatic logic [OUT_W-1:0] extend(input logic [SAMPLE_W-1:0] s);
      logic [OUT_W-1:0] r;
      r = '0;
      r[SAMPLE_W-1:0] = s;
      for (int i = SAMPLE_W; i < OUT_W; i++) r[i] = (SIGN_EXT != 0) ? s[SAMPLE_W-1] : 1'b0;
      return r;
   endfunction

   // Handshake: a word moves when tvalid and tready are both high at the rising edge;
   // tready depends only on registered state, never on tvalid.
   assign sample_in   = s00_axis_tdata[DATA_W-1 -: SAMPLE_W];
   assign accept      = s00_axis_tvalid & s00_axis_tready;
   assign out_free    = ((pending_q & ~m_axis_tready) == '0);
   assign last_word   = accept & (ch_idx_q == LAST_CH);
   assign load        = out_free & (gather_full_q | last_word);
   assign load_tlast  = gather_full_q ? held_tlast_q : s00_axis_tlast;
   assign at_last_grp = (grp_cnt_q == LAST_GRP);
   assign ends_frame  = at_last_grp | load_tlast;

   always_comb begin
      ch_idx_d      = ch_idx_q;
      gather_d      = gather_q;
      gather_full_d = gather_full_q;
      held_tlast_d  = held_tlast_q;
      pending_d     = pending_q & ~m_axis_tready;
      out_data_d    = out_data_q;
      out_last_d    = out_last_q;
      grp_cnt_d     = grp_cnt_q;
      frame_done_d  = 1'b0;
      frame_err_d   = 1'b0;
      err_cnt_d     = err_cnt_q;

      if (accept) begin
         if (s00_axis_tlast && (ch_idx_q != LAST_CH)) begin
            // Early tlast: the partial group is dropped and framing restarts.
            ch_idx_d    = '0;
            grp_cnt_d   = '0;
            frame_err_d = 1'b1;
         end else begin
            gather_d[ch_idx_q] = sample_in;
            ch_idx_d           = (ch_idx_q == LAST_CH) ? '0 : ch_idx_q + CW'(1);
            if ((ch_idx_q == LAST_CH) && !out_free) begin
               gather_full_d = 1'b1;
               held_tlast_d  = s00_axis_tlast;
            end
         end
      end

      if (load) begin
         for (int c = 0; c < NUM_CH; c++) out_data_d[c*OUT_W +: OUT_W] = extend(gather_d[c]);
         pending_d     = '1;
         out_last_d    = ends_frame;
         frame_done_d  = ends_frame;
         frame_err_d   = at_last_grp ^ load_tlast;
         grp_cnt_d     = ends_frame ? '0 : grp_cnt_q + GW'(1);
         gather_full_d = 1'b0;
      end

      if (frame_err_d && (err_cnt_q != 16'hFFFF)) err_cnt_d = err_cnt_q + 16'd1;
   end

   always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
      if (!s00_axis_aresetn) begin
         ch_idx_q      <= '0;
         for (int c = 0; c < NUM_CH; c++) gather_q[c] <= '0;
         gather_full_q <= 1'b0;
         held_tlast_q  <= 1'b0;
         pending_q     <= '0;
         out_data_q    <= '0;
         out_last_q    <= 1'b0;
         grp_cnt_q     <= '0;
         frame_done_q  <= 1'b0;
         frame_err_q   <= 1'b0;
         err_cnt_q     <= '0;
      end else begin
         ch_idx_q      <= ch_idx_d;
         gather_q      <= gather_d;
         gather_full_q <= gather_full_d;
         held_tlast_q  <= held_tlast_d;
         pending_q     <= pending_d;
         out_data_q    <= out_data_d;
         out_last_q    <= out_last_d;
         grp_cnt_q     <= grp_cnt_d;
         frame_done_q  <= frame_done_d;
         frame_err_q   <= frame_err_d;
         err_cnt_q     <= err_cnt_d;
      end
   end

   assign s00_axis_tready = ~gather_full_q;
   assign m_axis_tdata    = out_data_q;
   assign m_axis_tvalid   = pending_q;
   assign m_axis_tlast    = pending_q & {NUM_CH{out_last_q}};
   assign frame_done      = frame_done_q;
   assign frame_err       = frame_err_q;
   assign err_cnt         = err_cnt_q;

endmodule

// File: tb/tb_axis_tdm_deinterleave.sv
// Bench for axis_tdm_deinterleave: directed scenarios plus random traffic, checked against
// a group/frame model that turns the accepted input word stream into per-channel expected queues.
module tb_axis_tdm_deinterleave;
   localparam int NCH = 4;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [31:0]   s_tdata;
   logic          s_tvalid, s_tlast, s_tready, s_tready_z;
   logic [255:0]  m_data, m_data_z;
   logic [3:0]    m_valid, m_valid_z, m_last, m_last_z;
   logic [3:0]    m_ready = 4'hF;
   logic          f_done, f_err, f_done_z, f_err_z;
   logic [15:0]   e_cnt, e_cnt_z;

   int            checks = 0;
   int            errors = 0;
   logic [3:0]    hold_mask = 4'h0;
   bit            rand_rdy = 1'b0;

   // Reference model state
   logic [63:0]   exp_q [NCH][$];
   logic          exp_l [NCH][$];
   logic [31:0]   part [$];
   int            grp = 0;
   int            exp_cnt = 0, exp_errs = 0, exp_done = 0;
   int            obs_errs = 0, obs_done = 0, obs_last0 = 0;
   int            done0, last0;

   always #5 clk = ~clk;

   axis_tdm_deinterleave dut (
      .s00_axis_aclk(clk), .s00_axis_aresetn(rst_n), .s00_axis_tdata(s_tdata),
      .s00_axis_tvalid(s_tvalid), .s00_axis_tlast(s_tlast), .s00_axis_tready(s_tready),
      .m_axis_tdata(m_data), .m_axis_tvalid(m_valid), .m_axis_tready(m_ready),
      .m_axis_tlast(m_last), .frame_done(f_done), .frame_err(f_err), .err_cnt(e_cnt)
   );

   axis_tdm_deinterleave #(.SIGN_EXT(0)) dut_z (
      .s00_axis_aclk(clk), .s00_axis_aresetn(rst_n), .s00_axis_tdata(s_tdata),
      .s00_axis_tvalid(s_tvalid), .s00_axis_tlast(s_tlast), .s00_axis_tready(s_tready_z),
      .m_axis_tdata(m_data_z), .m_axis_tvalid(m_valid_z), .m_axis_tready(m_ready),
      .m_axis_tlast(m_last_z), .frame_done(f_done_z), .frame_err(f_err_z), .err_cnt(e_cnt_z)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [63:0] sx(input logic [31:0] w);
      logic [23:0] s;
      s = w[31:8];
      return {{40{s[23]}}, s};
   endfunction

   // Frame rules: group of NCH words -> one output per channel; tlast before the last
   // channel drops the group; a frame ends at group FRAME_LEN-1 or on tlast, and any
   // disagreement between the two is an error.
   task automatic model_accept(input logic [31:0] d, input logic l);
      bit endf, lastf;
      if (l && part.size() < NCH - 1) begin
         part.delete();
         grp = 0;
         exp_errs++;
         if (exp_cnt < 65535) exp_cnt++;
      end else begin
         part.push_back(d);
         if (part.size() == NCH) begin
            endf  = (grp == 4095);
            lastf = endf || l;
            if (endf != l) begin
               exp_errs++;
               if (exp_cnt < 65535) exp_cnt++;
            end
            if (lastf) exp_done++;
            for (int c = 0; c < NCH; c++) begin
               exp_q[c].push_back(sx(part[c]));
               exp_l[c].push_back(lastf);
            end
            grp = lastf ? 0 : grp + 1;
            part.delete();
         end
      end
   endtask

   // Called at a falling edge; returns at the falling edge after the word is taken.
   task automatic send(input logic [31:0] d, input logic l);
      int  t;
      bit  rdy;
      t = 0;
      s_tdata = d; s_tlast = l; s_tvalid = 1'b1;
      forever begin
         rdy = s_tready;
         @(posedge clk);
         if (rdy) begin
            model_accept(d, l);
            @(negedge clk);
            break;
         end
         @(negedge clk);
         t++;
         if (t > 2000) begin
            chk("send_timeout", 64'd1, 64'd0);
            break;
         end
      end
      s_tvalid = 1'b0; s_tlast = 1'b0;
   endtask

   task automatic drain();
      int t;
      t = 0;
      while ((exp_q[0].size() + exp_q[1].size() + exp_q[2].size() + exp_q[3].size()) != 0 && t < 500) begin
         @(negedge clk);
         t++;
      end
      chk("drain_empty", 64'(exp_q[0].size() + exp_q[1].size() + exp_q[2].size() + exp_q[3].size()), 64'd0);
   endtask

   // Output monitor: choose readies for the coming edge, then score every handshake.
   always @(negedge clk) begin
      m_ready = rand_rdy ? 4'($urandom) : 4'hF;
      m_ready = m_ready & ~hold_mask;
      if (rst_n === 1'b1) begin
         for (int c = 0; c < NCH; c++) begin
            if (m_valid[c] && m_ready[c]) begin
               if (exp_q[c].size() == 0) begin
                  chk($sformatf("unexpected_out_ch%0d", c), 64'd1, 64'd0);
               end else begin
                  chk($sformatf("data_ch%0d", c), m_data[c*64 +: 64], exp_q[c].pop_front());
                  chk($sformatf("last_ch%0d", c), 64'(m_last[c]), 64'(exp_l[c].pop_front()));
               end
               if (c == 0 && m_last[0]) obs_last0++;
            end
         end
         if (f_done) obs_done++;
         if (f_err)  obs_errs++;
      end
   end

   initial begin
      #900000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0; s_tvalid = 1'b0; s_tdata = '0; s_tlast = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_tvalid", 64'(m_valid), 64'h0);
      chk("rst_tlast", 64'(m_last), 64'h0);
      chk("rst_frame_done", 64'(f_done), 64'h0);
      chk("rst_frame_err", 64'(f_err), 64'h0);
      chk("rst_err_cnt", 64'(e_cnt), 64'h0);
      chk("rst_tready", 64'(s_tready), 64'h1);
      rst_n = 1'b1;
      @(negedge clk);

      // Basic group with sign extension
      send(32'h0000_0100, 1'b0);
      send(32'h0000_0200, 1'b0);
      send(32'hFFFF_FF00, 1'b0);
      send(32'h7FFF_FF00, 1'b0);
      chk("t1_tvalid", 64'(m_valid), 64'hF);
      chk("t1_ch0", m_data[0 +: 64], 64'h1);
      chk("t1_ch1", m_data[64 +: 64], 64'h2);
      chk("t1_ch2", m_data[128 +: 64], 64'hFFFF_FFFF_FFFF_FFFF);
      chk("t1_ch3", m_data[192 +: 64], 64'h7F_FFFF);
      chk("t1_zext_ch2", m_data_z[128 +: 64], 64'h0000_0000_00FF_FFFF);
      drain();

      // ch2 stalled for 10 cycles while input keeps streaming
      hold_mask = 4'b0100;
      fork
         begin
            for (int i = 0; i < 12; i++) send($urandom, 1'b0);
         end
         begin
            repeat (9) @(negedge clk);
            chk("t2_tready_low", 64'(s_tready), 64'h0);
            chk("t2_pending", 64'(m_valid), 64'h4);
            @(negedge clk);
            hold_mask = 4'b0000;
         end
      join
      drain();

      // Early tlast on ch1 of group 10
      for (int i = 0; i < 24; i++) send($urandom, 1'b0);
      send($urandom, 1'b0);
      send($urandom, 1'b1);
      repeat (3) @(negedge clk);
      chk("t4_err_cnt", 64'(e_cnt), 64'd1);
      chk("t4_err_pulses", 64'(obs_errs), 64'd1);
      drain();

      // Full frame with tlast on the final word
      done0 = obs_done;
      last0 = obs_last0;
      for (int g = 0; g < 4096; g++)
         for (int c = 0; c < NCH; c++) send($urandom, (g == 4095) && (c == NCH - 1));
      drain();
      chk("t3_done_pulses", 64'(obs_done - done0), 64'd1);
      chk("t3_tlast_count", 64'(obs_last0 - last0), 64'd1);
      chk("t3_err_pulses", 64'(obs_errs), 64'd1);
      chk("t3_err_cnt", 64'(e_cnt), 64'd1);

      // Random traffic, random readies, occasional tlast
      rand_rdy = 1'b1;
      for (int i = 0; i < 400; i++) begin
         repeat ($urandom_range(0, 2)) @(negedge clk);
         send($urandom, ($urandom_range(0, 39) == 0));
      end
      rand_rdy = 1'b0;
      drain();
      chk("rnd_err_cnt", 64'(e_cnt), 64'(exp_cnt));
      chk("rnd_err_pulses", 64'(obs_errs), 64'(exp_errs));
      chk("rnd_done_pulses", 64'(obs_done), 64'(exp_done));

      // Reset with pending=0101 and a half-full gather buffer
      while (part.size() != 0) send($urandom, 1'b0);
      drain();
      hold_mask = 4'b0101;
      repeat (2) @(negedge clk);
      for (int i = 0; i < 6; i++) send($urandom, 1'b0);
      chk("t6_pending", 64'(m_valid), 64'h5);
      #2 rst_n = 1'b0;
      #1;
      chk("t6_tvalid", 64'(m_valid), 64'h0);
      chk("t6_tlast", 64'(m_last), 64'h0);
      chk("t6_err_cnt", 64'(e_cnt), 64'h0);
      chk("t6_tready", 64'(s_tready), 64'h1);
      for (int c = 0; c < NCH; c++) begin
         exp_q[c].delete();
         exp_l[c].delete();
      end
      part.delete();
      grp = 0;
      exp_cnt = 0;
      @(negedge clk);
      rst_n = 1'b1;
      hold_mask = 4'b0000;
      @(negedge clk);
      send(32'h1234_5600, 1'b0);
      send(32'h0000_0A00, 1'b0);
      send(32'h0000_0B00, 1'b0);
      send(32'h0000_0C00, 1'b0);
      chk("t6_first_ch0", m_data[0 +: 64], 64'h12_3456);
      chk("t6_ch3", m_data[192 +: 64], 64'h0C);
      drain();

      // Zero extension versus sign extension of a negative full-scale sample
      send(32'h8000_0000, 1'b0);
      send(32'h0000_0100, 1'b0);
      send(32'h0000_0200, 1'b0);
      send(32'h0000_0300, 1'b0);
      chk("t5_zext_ch0", m_data_z[0 +: 64], 64'h0000_0000_0080_0000);
      chk("t5_sext_ch0", m_data[0 +: 64], 64'hFFFF_FFFF_FF80_0000);
      drain();
      chk("final_err_cnt", 64'(e_cnt), 64'(exp_cnt));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
